// File: rtl/uart_rx_buffer_pkg.sv
// Shared types for the UART receive buffer: capture FSM state encoding.
package uart_rx_buffer_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_LOW = 1'b1
    } cap_state_t;

endpackage

// File: rtl/uart_rx_buffer_byte_fifo.sv
// First-word fall-through byte FIFO with registered count/full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module byte_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic                 push_ok,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count
);

    localparam logic [ADDR_BITS:0] ONE = (ADDR_BITS+1)'(1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic               do_push, do_pop;
    logic               empty_nxt, full_nxt;

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign push_ok = do_push;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push) begin
            wr_ptr_nxt = wr_ptr + ONE;
        end
        if (do_pop) begin
            rd_ptr_nxt = rd_ptr + ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt  = (wr_ptr_nxt[ADDR_BITS-1:0] == rd_ptr_nxt[ADDR_BITS-1:0]) &&
                    (wr_ptr_nxt[ADDR_BITS] != rd_ptr_nxt[ADDR_BITS]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= empty_nxt;
            full   <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_BITS-1:0]] <= push_data;
        end
    end

    assign rd_data = mem[rd_ptr[ADDR_BITS-1:0]];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: acknowledges each uart byte once, queues it in a FIFO,
// and raises a sticky overrun flag when a byte has to be dropped.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_rdy,
    input  logic [7:0]           rx_data,
    output logic                 rx_rdy_clr,
    input  logic                 rd_en,
    output logic [7:0]           rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    cap_state_t state, state_nxt;
    logic       push_req;
    logic       push_ok;
    logic       ack_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rx_rdy_clr <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_rdy_clr <= ack_nxt;
        end
    end

    // WAIT_LOW blocks re-capture until the uart drops rdy, however slowly.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    push_req  = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!rx_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push_req && !push_ok) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    byte_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (rd_en),
        .push_ok   (push_ok),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

endmodule
